multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 6, opcode width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have opcode  input  WIDTH  instruction[31:26] from the instruction register.
REQ-005 SHALL have zero  input  1  ALU zero flag, sampled in BR state.
REQ-006 SHALL have mem_ack  input  1  memory completion, valid only while mem_req is high.
REQ-007 SHALL have mem_req  output  1  memory access request.
REQ-008 SHALL have mem_we  output  1  memory write qualifier for mem_req.
REQ-009 SHALL have iord  output  1  address select: 0 = PC, 1 = ALUOut.
REQ-010 SHALL have ir_we, pc_we, reg_we  output  1 each  register-file, PC and IR write enables.
REQ-011 SHALL have reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-012 SHALL have alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-013 SHALL have alu_op  output  2  00 add, 01 sub, 10 use funct.
REQ-014 SHALL have pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-015 SHALL have instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-016 SHALL have state  output  4  current state code, for debug.

Function
REQ-017 SHALL implement states IF, ID, MADR, MRD, MWB, MWR, REX, RWB, IEX, IWB, BR, JMP.
REQ-018 IF SHALL assert mem_req, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_we and pc_we only in the cycle mem_ack=1; then go to ID; otherwise hold.
REQ-019 ID SHALL set alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute), then decode: 000000->REX, 001000->IEX, 100011/101011->MADR, 000100->BR, 000010->JMP, any other->IF with instr_done=1 (nop).
REQ-020 MADR SHALL set alu_src_a=1, alu_src_b=10, alu_op=00; next MRD for lw, MWR for sw.
REQ-021 MRD SHALL assert mem_req, iord=1, mem_we=0; hold until mem_ack, then MWB.
REQ-022 MWB SHALL assert reg_we, reg_dst=0, mem_to_reg=1, instr_done; next IF.
REQ-023 MWR SHALL assert mem_req, mem_we=1, iord=1; hold until mem_ack; on ack pulse instr_done, next IF.
REQ-024 REX SHALL set alu_src_a=1, alu_src_b=00, alu_op=10; RWB SHALL assert reg_we, reg_dst=1, mem_to_reg=0, instr_done.
REQ-025 IEX SHALL set alu_src_a=1, alu_src_b=10, alu_op=00; IWB SHALL assert reg_we, reg_dst=0, mem_to_reg=0, instr_done.
REQ-026 BR SHALL set alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero, instr_done; next IF.
REQ-027 JMP SHALL set pc_src=10, pc_we=1, instr_done; next IF.
REQ-028 All outputs SHALL be Moore-decoded from state, except ir_we/pc_we gated by mem_ack (IF) and pc_we gated by zero (BR); unused enables SHALL be 0 and unused selects 0.
REQ-029 Latencies with mem_ack tied high: add/addi 4 cycles, lw 5, sw 4, beq 3, j 3, nop 2.
REQ-030 Each memory-state stall cycle SHALL add exactly one cycle with all write enables low.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-032 rst_n low SHALL force state=IF immediately, independent of clk.
REQ-033 During reset all enables, mem_req and instr_done SHALL be 0 and all selects 0.
REQ-034 Reset mid-instruction SHALL abandon it with no further writes; fetch restarts at the first rising edge after rst_n deasserts.

Structure
REQ-035 State codes and opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J) SHALL live in shared package mc_ctrl_pkg.
REQ-036 One sub-module, mc_ctrl_outdec (combinational state -> control vector), SHALL be instantiated; next-state logic and the state register stay in multicycle_ctrl.

Verification
REQ-037 Reset: rst_n=0 mid-MRD -> state=IF, all enables 0 within the same cycle; first IF after release.
REQ-038 add, mem_ack=1: state sequence IF,ID,REX,RWB; reg_we=1, reg_dst=1 only in cycle 4; instr_done once.
REQ-039 lw with mem_ack delayed 3 cycles in MRD: 8 cycles total; reg_we=1 only in MWB with mem_to_reg=1.
REQ-040 beq, zero=1 -> pc_we=1, pc_src=01 in BR; repeat with zero=0 -> pc_we=0; both 3 cycles.
REQ-041 sw then j: mem_we=1 only in MWR; j gives pc_src=10, pc_we=1; reg_we never asserted.
REQ-042 opcode 6'b111111: IF, ID, back to IF; no enables; instr_done pulses in ID.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_pkg : state codes, opcodes and control-vector type for multicycle_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_IEX  = 4'd8,
    S_IWB  = 4'd9,
    S_BR   = 4'd10,
    S_JMP  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ)  || (op == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_outdec : combinational state -> control vector decode
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ack,
  input  logic   zero,
  input  logic   id_nop,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_we     = mem_ack;
        ctrl.pc_we     = mem_ack;
      end
      S_ID: begin
        ctrl.alu_src_b  = 2'b11;
        ctrl.instr_done = id_nop;
      end
      S_MADR, S_IEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_we     = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ack;
      end
      S_REX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_RWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_IWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BR: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = 2'b01;
        ctrl.pc_src     = 2'b01;
        ctrl.pc_we      = zero;
        ctrl.instr_done = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_src     = 2'b10;
        ctrl.pc_we      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl : multicycle MIPS-style control FSM (state register + next state)
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic [3:0]       state
);

  state_e     state_q, state_d;
  logic [5:0] op6;
  logic       id_nop;
  ctrl_t      ctrl_dec;
  ctrl_t      ctrl_out;

  assign op6    = 6'(opcode);
  assign id_nop = (state_q == S_ID) && !is_known_op(op6);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (mem_ack) state_d = S_ID;
      S_ID: begin
        case (op6)
          OP_RTYPE:     state_d = S_REX;
          OP_ADDI:      state_d = S_IEX;
          OP_LW, OP_SW: state_d = S_MADR;
          OP_BEQ:       state_d = S_BR;
          OP_J:         state_d = S_JMP;
          default:      state_d = S_IF;
        endcase
      end
      S_MADR: state_d = (op6 == OP_SW) ? S_MWR : S_MRD;
      S_MRD:  if (mem_ack) state_d = S_MWB;
      S_MWR:  if (mem_ack) state_d = S_IF;
      S_REX:  state_d = S_RWB;
      S_IEX:  state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  mc_ctrl_outdec u_outdec (
    .state   (state_q),
    .mem_ack (mem_ack),
    .zero    (zero),
    .id_nop  (id_nop),
    .ctrl    (ctrl_dec)
  );

  // IF would otherwise request memory while reset is held; quiesce everything.
  assign ctrl_out = rst_n ? ctrl_dec : '0;

  assign mem_req    = ctrl_out.mem_req;
  assign mem_we     = ctrl_out.mem_we;
  assign iord       = ctrl_out.iord;
  assign ir_we      = ctrl_out.ir_we;
  assign pc_we      = ctrl_out.pc_we;
  assign reg_we     = ctrl_out.reg_we;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign pc_src     = ctrl_out.pc_src;
  assign instr_done = ctrl_out.instr_done;
  assign state      = state_q;

endmodule
`default_nettype wire
